// File: rtl/adc_conv_sequencer.sv
// rtl/adc_conv_sequencer.sv - periodic serial ADC conversion sequencer with valid/ready word output
module adc_conv_sequencer #(
    parameter int DATA_BITS     = 16,
    parameter int CLK_DIV       = 2,
    parameter int T_CONV        = 150,
    parameter int SAMPLE_PERIOD = 420
) (
    input  logic                 clk210_p,
    input  logic                 reset_p,
    input  logic                 enable_p,
    output logic                 cnv_p,
    output logic                 sck_p,
    input  logic                 sdo_p,
    output logic [DATA_BITS-1:0] sample_data_p,
    output logic                 sample_valid_p,
    input  logic                 sample_ready_p,
    output logic                 overrun_p,
    output logic                 busy_p
);

    // Shortest period that still fits a whole frame plus one WAIT cycle.
    localparam int FRAME_CYCLES = T_CONV + 2 * CLK_DIV * DATA_BITS + 2;
    localparam logic SHORT_PERIOD = (SAMPLE_PERIOD < FRAME_CYCLES) ? 1'b1 : 1'b0;

    localparam int PER_W  = $clog2(SAMPLE_PERIOD + 1);
    localparam int CONV_W = $clog2(T_CONV + 1);
    localparam int DIV_W  = $clog2(2 * CLK_DIV + 1);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(T_CONV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_SHIFT,
        S_LOAD,
        S_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [PER_W-1:0]      r_period_cnt;
    logic [CONV_W-1:0]     r_conv_cnt;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_valid;
    logic                  r_overrun;

    logic                  w_conv_done;
    logic                  w_sck_fall;
    logic                  w_last_bit;
    logic                  w_wait_done;
    logic                  w_start_conv;

    assign w_conv_done = (r_conv_cnt == CONV_LAST);
    assign w_sck_fall  = (r_state == S_SHIFT) && (r_div_cnt == DIV_LAST);
    assign w_last_bit  = (r_bit_cnt == BIT_LAST);
    // A too-short period degrades to back-to-back frames with a single WAIT cycle.
    assign w_wait_done = SHORT_PERIOD || (r_period_cnt == PER_LAST);

    assign cnv_p          = (r_state == S_CONV);
    assign sck_p          = (r_state == S_SHIFT) && (r_div_cnt >= DIV_HALF);
    assign busy_p         = (r_state != S_IDLE);
    assign sample_data_p  = r_data;
    assign sample_valid_p = r_valid;
    assign overrun_p      = r_overrun;

    // State register.
    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; enable_p only matters in IDLE and at the end of WAIT.
    always_comb begin
        w_next_state = r_state;
        w_start_conv = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable_p) begin
                    w_next_state = S_CONV;
                    w_start_conv = 1'b1;
                end
            end
            S_CONV: begin
                if (w_conv_done) begin
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_sck_fall && w_last_bit) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (w_wait_done) begin
                    if (enable_p) begin
                        w_next_state = S_CONV;
                        w_start_conv = 1'b1;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Sample-period counter: zero on every CONV entry, free-running and wrapping while busy.
    always_ff @(posedge clk210_p) begin
        if (reset_p || w_start_conv) begin
            r_period_cnt <= '0;
        end else if (r_state != S_IDLE) begin
            if (r_period_cnt == PER_LAST) begin
                r_period_cnt <= '0;
            end else begin
                r_period_cnt <= r_period_cnt + PER_W'(1);
            end
        end
    end

    // Conversion-time counter, only runs while cnv_p is high.
    always_ff @(posedge clk210_p) begin
        if (reset_p || (r_state != S_CONV)) begin
            r_conv_cnt <= '0;
        end else begin
            r_conv_cnt <= r_conv_cnt + CONV_W'(1);
        end
    end

    // sck_p phase divider and bit counter; a bit completes on each sck_p falling edge.
    always_ff @(posedge clk210_p) begin
        if (reset_p || (r_state != S_SHIFT)) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_sck_fall) begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
        end
    end

    // Capture sdo_p MSB-first on the edge where sck_p falls.
    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            r_shift <= '0;
        end else if (w_sck_fall) begin
            r_shift <= {r_shift[DATA_BITS-2:0], sdo_p};
        end
    end

    // Output word register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_state == S_LOAD) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
            if (r_valid && !sample_ready_p) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && sample_ready_p) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// tb/tb_adc_conv_sequencer.sv - self-checking bench for adc_conv_sequencer
module tb_adc_conv_sequencer;

    logic        clk210_p;
    logic        reset_p;
    logic        enable_p;
    logic        cnv_p;
    logic        sck_p;
    logic        sdo_p = 1'b0;
    logic [15:0] sample_data_p;
    logic        sample_valid_p;
    logic        sample_ready_p;
    logic        overrun_p;
    logic        busy_p;

    logic        reset2;
    logic        enable2;
    logic        cnv2;
    logic        sck2;
    logic        sdo2;
    logic [15:0] data2;
    logic        valid2;
    logic        ready2;
    logic        overrun2;
    logic        busy2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    adc_conv_sequencer #(
        .DATA_BITS(16), .CLK_DIV(2), .T_CONV(150), .SAMPLE_PERIOD(420)
    ) u_dut (
        .clk210_p      (clk210_p),
        .reset_p       (reset_p),
        .enable_p      (enable_p),
        .cnv_p         (cnv_p),
        .sck_p         (sck_p),
        .sdo_p         (sdo_p),
        .sample_data_p (sample_data_p),
        .sample_valid_p(sample_valid_p),
        .sample_ready_p(sample_ready_p),
        .overrun_p     (overrun_p),
        .busy_p        (busy_p)
    );

    adc_conv_sequencer #(
        .DATA_BITS(16), .CLK_DIV(2), .T_CONV(150), .SAMPLE_PERIOD(100)
    ) u_dut_short (
        .clk210_p      (clk210_p),
        .reset_p       (reset2),
        .enable_p      (enable2),
        .cnv_p         (cnv2),
        .sck_p         (sck2),
        .sdo_p         (sdo2),
        .sample_data_p (data2),
        .sample_valid_p(valid2),
        .sample_ready_p(ready2),
        .overrun_p     (overrun2),
        .busy_p        (busy2)
    );

    initial clk210_p = 1'b0;
    always #5 clk210_p = ~clk210_p;

    always @(posedge clk210_p) cyc <= cyc + 1;

    // ADC model + scoreboard for the default instance
    logic [15:0] adc_words[$];
    logic [15:0] exp_q[$];
    logic [15:0] adc_default = 16'hFFFF;
    logic [15:0] adc_word = 16'h0000;
    logic [15:0] exp_w;
    int          cnv_rises[$];
    int          cnv_falls[$];
    int          sck_rises[$];
    int          sck_falls[$];
    int          valid_rises[$];
    int          hs_count = 0;
    int          adc_idx = 0;
    logic        p_cnv = 1'b0;
    logic        p_sck = 1'b0;
    logic        p_valid = 1'b0;

    always @(negedge clk210_p) begin
        if (cnv_p && !p_cnv) begin
            cnv_rises.push_back(cyc);
            if (adc_words.size() > 0) adc_word = adc_words.pop_front();
            else adc_word = adc_default;
            exp_q.push_back(adc_word);
            adc_idx = 0;
        end
        if (!cnv_p && p_cnv) cnv_falls.push_back(cyc);
        if (sck_p && !p_sck) begin
            sck_rises.push_back(cyc);
            if (adc_idx < 16) begin
                sdo_p = adc_word[15 - adc_idx];
                adc_idx++;
            end
        end
        if (!sck_p && p_sck) sck_falls.push_back(cyc);
        if (sample_valid_p && !p_valid) valid_rises.push_back(cyc);
        if (sample_valid_p && sample_ready_p) begin
            hs_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL hs_unexpected: got word %h, no word expected", sample_data_p);
            end else begin
                exp_w = exp_q.pop_front();
                if (sample_data_p !== exp_w) begin
                    failures++;
                    $display("FAIL hs_data: got %h expected %h", sample_data_p, exp_w);
                end
            end
        end
        p_cnv   = cnv_p;
        p_sck   = sck_p;
        p_valid = sample_valid_p;
    end

    // Monitor for the short-period instance
    int   cnv2_rises[$];
    int   valid2_rises[$];
    int   sck2_per_frame[$];
    int   sck2_cnt = 0;
    logic p_cnv2 = 1'b0;
    logic p_sck2 = 1'b0;
    logic p_valid2 = 1'b0;

    always @(negedge clk210_p) begin
        if (cnv2 && !p_cnv2) begin
            cnv2_rises.push_back(cyc);
            sck2_cnt = 0;
        end
        if (sck2 && !p_sck2) sck2_cnt++;
        if (valid2 && !p_valid2) begin
            valid2_rises.push_back(cyc);
            sck2_per_frame.push_back(sck2_cnt);
        end
        if (valid2 && ready2) begin
            checks++;
            if (data2 !== 16'hFFFF) begin
                failures++;
                $display("FAIL short_data: got %h expected ffff", data2);
            end
        end
        p_cnv2   = cnv2;
        p_sck2   = sck2;
        p_valid2 = valid2;
    end

    task automatic step();
        @(posedge clk210_p);
        #1;
    endtask

    task automatic clear_monitor();
        adc_words.delete();
        exp_q.delete();
        cnv_rises.delete();
        cnv_falls.delete();
        sck_rises.delete();
        sck_falls.delete();
        valid_rises.delete();
        hs_count = 0;
    endtask

    task automatic do_reset();
        reset_p = 1'b1;
        enable_p = 1'b0;
        sample_ready_p = 1'b0;
        step();
        step();
        reset_p = 1'b0;
        clear_monitor();
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 1000 && busy_p; i++) step();
        checks++;
        if (busy_p !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_timeout: busy=%b expected 0", name, busy_p);
        end
    endtask

    task automatic test_reset();
        reset_p = 1'b1;
        enable_p = 1'b1;
        sample_ready_p = 1'b0;
        step();
        step();
        checks++; if (cnv_p !== 1'b0) begin failures++; $display("FAIL rst_cnv: got %b expected 0", cnv_p); end
        checks++; if (sck_p !== 1'b0) begin failures++; $display("FAIL rst_sck: got %b expected 0", sck_p); end
        checks++; if (sample_valid_p !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", sample_valid_p); end
        checks++; if (busy_p !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy_p); end
        checks++; if (overrun_p !== 1'b0) begin failures++; $display("FAIL rst_overrun: got %b expected 0", overrun_p); end
        checks++; if (sample_data_p !== 16'h0000) begin failures++; $display("FAIL rst_data: got %h expected 0000", sample_data_p); end
        enable_p = 1'b0;
        reset_p = 1'b0;
        clear_monitor();
        for (int i = 0; i < 10; i++) step();
        checks++; if (busy_p !== 1'b0) begin failures++; $display("FAIL rst_idle_busy: got %b expected 0", busy_p); end
        checks++; if (cnv_rises.size() != 0) begin failures++; $display("FAIL rst_idle_cnv: got %0d rises expected 0", cnv_rises.size()); end
    endtask

    task automatic test_all_ones();
        int t_en;
        do_reset();
        adc_default = 16'hFFFF;
        sample_ready_p = 1'b1;
        t_en = cyc;
        enable_p = 1'b1;
        for (int i = 0; i < 1500 && cnv_rises.size() < 3; i++) step();
        checks++;
        if (cnv_rises.size() < 3) begin
            failures++;
            $display("FAIL ones_cnv_timeout: got %0d rises expected 3", cnv_rises.size());
        end else begin
            checks++; if (cnv_rises[0] != t_en + 1) begin failures++; $display("FAIL ones_start_latency: got %0d expected %0d", cnv_rises[0] - t_en, 1); end
            checks++; if (cnv_rises[1] - cnv_rises[0] != 420) begin failures++; $display("FAIL ones_period1: got %0d expected 420", cnv_rises[1] - cnv_rises[0]); end
            checks++; if (cnv_rises[2] - cnv_rises[1] != 420) begin failures++; $display("FAIL ones_period2: got %0d expected 420", cnv_rises[2] - cnv_rises[1]); end
            checks++; if (hs_count != 2) begin failures++; $display("FAIL ones_hs_count: got %0d expected 2", hs_count); end
        end
        enable_p = 1'b0;
        wait_idle("ones");
        checks++; if (overrun_p !== 1'b0) begin failures++; $display("FAIL ones_overrun: got %b expected 0", overrun_p); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ones_words_left: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_adc_pattern();
        int bad;
        do_reset();
        adc_words.push_back(16'hA5C3);
        sample_ready_p = 1'b1;
        enable_p = 1'b1;
        for (int i = 0; i < 20 && cnv_rises.size() < 1; i++) step();
        enable_p = 1'b0;
        wait_idle("pattern");
        checks++;
        if (cnv_rises.size() != 1 || cnv_falls.size() != 1 || valid_rises.size() != 1) begin
            failures++;
            $display("FAIL pattern_events: got cnv=%0d/%0d valid=%0d expected 1/1/1",
                     cnv_rises.size(), cnv_falls.size(), valid_rises.size());
        end else begin
            checks++; if (cnv_falls[0] - cnv_rises[0] != 150) begin failures++; $display("FAIL pattern_conv_len: got %0d expected 150", cnv_falls[0] - cnv_rises[0]); end
            checks++; if (valid_rises[0] - cnv_rises[0] != 215) begin failures++; $display("FAIL pattern_valid_latency: got %0d expected 215", valid_rises[0] - cnv_rises[0]); end
        end
        checks++;
        if (sck_rises.size() != 16 || sck_falls.size() != 16) begin
            failures++;
            $display("FAIL pattern_sck_count: got %0d/%0d expected 16/16", sck_rises.size(), sck_falls.size());
        end else begin
            bad = 0;
            for (int k = 0; k < 16; k++) begin
                if (sck_falls[k] - sck_rises[k] != 2) bad++;
                if (k > 0 && sck_rises[k] - sck_rises[k-1] != 4) bad++;
            end
            checks++; if (bad != 0) begin failures++; $display("FAIL pattern_sck_timing: got %0d bad pulses expected 0", bad); end
            if (cnv_falls.size() == 1) begin
                checks++; if (sck_rises[0] - cnv_falls[0] != 2) begin failures++; $display("FAIL pattern_sck_first: got %0d expected 2", sck_rises[0] - cnv_falls[0]); end
            end
        end
        checks++; if (hs_count != 1) begin failures++; $display("FAIL pattern_hs_count: got %0d expected 1", hs_count); end
    endtask

    task automatic test_overrun();
        int hs0;
        do_reset();
        adc_words.push_back(16'h1111);
        adc_words.push_back(16'h2222);
        sample_ready_p = 1'b0;
        enable_p = 1'b1;
        for (int i = 0; i < 1000 && cnv_rises.size() < 2; i++) step();
        checks++;
        if (cnv_rises.size() < 2) begin
            failures++;
            $display("FAIL ovr_cnv_timeout: got %0d rises expected 2", cnv_rises.size());
        end else begin
            for (int i = 0; i < 400 && cyc < cnv_rises[1] + 215; i++) step();
        end
        enable_p = 1'b0;
        checks++; if (overrun_p !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b expected 1", overrun_p); end
        checks++; if (sample_valid_p !== 1'b1) begin failures++; $display("FAIL ovr_valid: got %b expected 1", sample_valid_p); end
        checks++; if (sample_data_p !== 16'h2222) begin failures++; $display("FAIL ovr_data: got %h expected 2222", sample_data_p); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        hs0 = hs_count;
        sample_ready_p = 1'b1;
        step();
        checks++; if (sample_valid_p !== 1'b0) begin failures++; $display("FAIL ovr_valid_drop: got %b expected 0", sample_valid_p); end
        for (int i = 0; i < 5; i++) step();
        checks++; if (hs_count != hs0 + 1) begin failures++; $display("FAIL ovr_hs_count: got %0d expected %0d", hs_count, hs0 + 1); end
        checks++; if (overrun_p !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b expected 1", overrun_p); end
        wait_idle("ovr");
    endtask

    task automatic test_disable_mid();
        do_reset();
        adc_words.push_back(16'h5A3C);
        sample_ready_p = 1'b1;
        enable_p = 1'b1;
        for (int i = 0; i < 1000 && sck_rises.size() < 6; i++) step();
        enable_p = 1'b0;
        wait_idle("dis");
        checks++; if (cnv_rises.size() != 1) begin failures++; $display("FAIL dis_cnv_count: got %0d expected 1", cnv_rises.size()); end
        checks++; if (sck_rises.size() != 16) begin failures++; $display("FAIL dis_sck_count: got %0d expected 16", sck_rises.size()); end
        checks++; if (hs_count != 1) begin failures++; $display("FAIL dis_hs_count: got %0d expected 1", hs_count); end
        for (int i = 0; i < 500; i++) step();
        checks++; if (cnv_rises.size() != 1) begin failures++; $display("FAIL dis_no_restart: got %0d rises expected 1", cnv_rises.size()); end
    endtask

    task automatic test_reset_mid();
        int t_rel;
        do_reset();
        adc_words.push_back(16'h1234);
        adc_words.push_back(16'hBEEF);
        sample_ready_p = 1'b1;
        enable_p = 1'b1;
        for (int i = 0; i < 1000 && sck_rises.size() < 9; i++) step();
        reset_p = 1'b1;
        step();
        checks++; if (cnv_p !== 1'b0) begin failures++; $display("FAIL rmid_cnv: got %b expected 0", cnv_p); end
        checks++; if (sck_p !== 1'b0) begin failures++; $display("FAIL rmid_sck: got %b expected 0", sck_p); end
        checks++; if (sample_valid_p !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b expected 0", sample_valid_p); end
        checks++; if (busy_p !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b expected 0", busy_p); end
        t_rel = cyc;
        reset_p = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 10 && cnv_rises.size() < 2; i++) step();
        enable_p = 1'b0;
        checks++;
        if (cnv_rises.size() < 2) begin
            failures++;
            $display("FAIL rmid_restart_timeout: got %0d rises expected 2", cnv_rises.size());
        end else if (cnv_rises[1] != t_rel + 1) begin
            failures++;
            $display("FAIL rmid_restart_latency: got %0d expected 1", cnv_rises[1] - t_rel);
        end
        for (int i = 0; i < 500 && hs_count < 1; i++) step();
        checks++; if (hs_count != 1) begin failures++; $display("FAIL rmid_hs_count: got %0d expected 1", hs_count); end
        checks++; if (overrun_p !== 1'b0) begin failures++; $display("FAIL rmid_overrun: got %b expected 0", overrun_p); end
        wait_idle("rmid");
    endtask

    task automatic test_short_period();
        int bad;
        reset2 = 1'b1;
        enable2 = 1'b0;
        step();
        step();
        reset2 = 1'b0;
        cnv2_rises.delete();
        valid2_rises.delete();
        sck2_per_frame.delete();
        enable2 = 1'b1;
        for (int i = 0; i < 1500 && cnv2_rises.size() < 4; i++) step();
        checks++;
        if (cnv2_rises.size() < 4 || valid2_rises.size() < 3) begin
            failures++;
            $display("FAIL short_timeout: got %0d rises %0d words expected 4/3", cnv2_rises.size(), valid2_rises.size());
        end else begin
            bad = 0;
            for (int k = 1; k < 4; k++) if (cnv2_rises[k] - cnv2_rises[k-1] != 216) bad++;
            checks++; if (bad != 0) begin failures++; $display("FAIL short_period: got %0d expected 216 (bad=%0d)", cnv2_rises[1] - cnv2_rises[0], bad); end
            bad = 0;
            for (int k = 0; k < 3; k++) if (sck2_per_frame[k] != 16) bad++;
            checks++; if (bad != 0) begin failures++; $display("FAIL short_bits: got %0d expected 16 (bad=%0d)", sck2_per_frame[0], bad); end
            checks++; if (valid2_rises[0] - cnv2_rises[0] != 215) begin failures++; $display("FAIL short_latency: got %0d expected 215", valid2_rises[0] - cnv2_rises[0]); end
        end
        checks++; if (overrun2 !== 1'b0) begin failures++; $display("FAIL short_overrun: got %b expected 0", overrun2); end
        enable2 = 1'b0;
    endtask

    initial begin
        reset_p = 1'b1;
        enable_p = 1'b0;
        sample_ready_p = 1'b0;
        reset2 = 1'b1;
        enable2 = 1'b0;
        sdo2 = 1'b1;
        ready2 = 1'b1;
        test_reset();
        test_all_ones();
        test_adc_pattern();
        test_overrun();
        test_disable_mid();
        test_reset_mid();
        test_short_period();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
